// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding and counter width.
package dmem_arb_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK  = 2'd1,
    GUARD = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single d_mem port between the CPU M-stage and the debug/loader port.
// CPU has default priority; debug gets a bounded wait and may lock the port for bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_stall,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic          i_dbg_lock,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  output logic          o_dbg_gnt,
  output logic [DW-1:0] o_dbg_rdata,
  output logic          o_dbg_rvalid,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rd
);

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] LockLast  = CNT_W'(LOCK_MAX - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [DW-1:0]    dbg_rdata_q, dbg_rdata_d;
  logic             dbg_rvalid_q, dbg_rvalid_d;
  owner_t           owner;

  // Nobody owns the port while in reset, so no write or stall escapes.
  always_comb begin
    owner = OWN_NONE;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (i_dbg_req && (!i_cpu_req || wait_cnt_q == StarveMax)) owner = OWN_DBG;
          else if (i_cpu_req)                                       owner = OWN_CPU;
        end
        LOCK:    if (i_dbg_req) owner = OWN_DBG;
        GUARD:   if (i_cpu_req) owner = OWN_CPU;
        default: owner = OWN_NONE;
      endcase
    end
  end

  always_comb begin
    o_dbg_gnt   = (owner == OWN_DBG);
    o_cpu_stall = i_cpu_req && !rst && (owner != OWN_CPU);
    o_mem_we    = o_dbg_gnt ? i_dbg_we : ((owner == OWN_CPU) && i_cpu_we);
    o_mem_addr  = o_dbg_gnt ? i_dbg_addr : i_cpu_addr;
    o_mem_wdata = o_dbg_gnt ? i_dbg_wdata : i_cpu_wdata;
    o_cpu_rdata = i_mem_rd;
    o_dbg_rdata  = dbg_rdata_q;
    o_dbg_rvalid = dbg_rvalid_q;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lock_cnt_d = lock_cnt_q;

    // Starvation counter only advances in ARB; it is frozen across LOCK/GUARD.
    if (!i_dbg_req || o_dbg_gnt) begin
      wait_cnt_d = '0;
    end else if (state_q == ARB && wait_cnt_q < StarveMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    case (state_q)
      ARB: begin
        if (o_dbg_gnt && i_dbg_lock) begin
          state_d    = LOCK;
          lock_cnt_d = '0;
        end
      end
      LOCK: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (!i_dbg_lock)                state_d = ARB;
        else if (lock_cnt_q == LockLast) state_d = GUARD;
      end
      GUARD:   state_d = ARB;
      default: state_d = ARB;
    endcase

    dbg_rvalid_d = o_dbg_gnt && !i_dbg_we;
    dbg_rdata_d  = dbg_rvalid_d ? i_mem_rd : dbg_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      wait_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the processor's memory-stage port and a debug/loader port used for program load and memory inspection.
- The processor has default priority. The debug port is guaranteed service after a bounded wait and may lock the port for multi-word bursts.
- Sits between the processor/debug master and d_mem, driving d_mem's we/a/wd and routing its combinational rd back to the owner.

Parameters:
- DW, 32, data width.
- AW, 32, address width.
- STARVE_MAX, 8, consecutive denied debug-request cycles before debug preempts the CPU (range 1..255).
- LOCK_MAX, 16, maximum cycles debug may hold a lock before forced release (range 1..255).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- i_cpu_req  input  1  CPU memory access this cycle (load or store in M stage).
- i_cpu_we  input  1  CPU store.
- i_cpu_addr  input  AW  CPU address.
- i_cpu_wdata  input  DW  CPU store data.
- o_cpu_rdata  output  DW  CPU load data, combinational from memory.
- o_cpu_stall  output  1  CPU access not performed this cycle; pipeline must hold.
- i_dbg_req  input  1  debug access request, held until granted.
- i_dbg_we  input  1  debug write.
- i_dbg_lock  input  1  keep ownership after this grant.
- i_dbg_addr  input  AW  debug address.
- i_dbg_wdata  input  DW  debug write data.
- o_dbg_gnt  output  1  debug access performed this cycle.
- o_dbg_rdata  output  DW  registered debug read data.
- o_dbg_rvalid  output  1  o_dbg_rdata valid; one-cycle pulse.
- o_mem_we  output  1  to d_mem we.
- o_mem_addr  output  AW  to d_mem a.
- o_mem_wdata  output  DW  to d_mem wd.
- i_mem_rd  input  DW  from d_mem rd.

Behaviour:
- FSM states: ARB (reset state), LOCK, GUARD.
- Owner selection is combinational each cycle. Memory outputs mux the owner's we/addr/wdata. With no owner: o_mem_we=0, addr/wdata = CPU values.
- ARB: debug wins if i_dbg_req && (!i_cpu_req || wait_cnt==STARVE_MAX). Otherwise the CPU wins when i_cpu_req.
- LOCK: debug wins whenever i_dbg_req. The CPU never wins.
- GUARD: the CPU wins if i_cpu_req. Debug is never granted.
- o_dbg_gnt = debug owns the cycle.
- o_cpu_stall = i_cpu_req && !CPU-owns. A stalled CPU access performs no write.
- o_cpu_rdata = i_mem_rd always. The value is only meaningful when not stalled.
- Debug read (gnt && !i_dbg_we): o_dbg_rdata <= i_mem_rd at the edge; o_dbg_rvalid=1 the next cycle only. Debug writes produce no rvalid.
- wait_cnt (8 bit):
  - In ARB, increments (saturating at STARVE_MAX) on i_dbg_req && !o_dbg_gnt.
  - Clears on debug grant or when !i_dbg_req.
  - Held in LOCK/GUARD.
- lock_cnt (8 bit): cleared on entry to LOCK, increments each LOCK cycle.
- Transitions:
  - ARB->LOCK at the edge of a debug grant with i_dbg_lock=1.
  - LOCK->ARB at an edge where i_dbg_lock=0. The cycle that samples the 0 is still LOCK-owned.
  - LOCK->GUARD at an edge where lock_cnt==LOCK_MAX-1 and i_dbg_lock=1 (forced release).
  - GUARD->ARB after exactly one cycle.
- A debug grant in ARB with i_dbg_lock=0 stays in ARB; the CPU competes normally next cycle.
- Simultaneous requests with wait_cnt<STARVE_MAX: the CPU wins, debug waits. At wait_cnt==STARVE_MAX debug wins and the CPU stalls one cycle.
- Reset (any cycle, including mid-LOCK or with a pending rvalid):
  - state=ARB, wait_cnt=0, lock_cnt=0, o_dbg_rvalid=0, o_dbg_rdata=0.
  - While rst=1: o_mem_we=0, o_dbg_gnt=0, o_cpu_stall=0 (pipeline is itself in reset).
- Addresses and data pass through unmodified; no width arithmetic beyond the counters.

Decomposition:
- Package dmem_arb_pkg: state enum arb_state_t {ARB, LOCK, GUARD}; owner enum {OWN_NONE, OWN_CPU, OWN_DBG}; counter width constant CNT_W=8.
- No sub-module is needed. The grant logic, FSM, counters and read-return register stay flat in one module.

Test Plan:
- CPU only: i_cpu_req=1, we=1, addr=0x10, wdata=0xDEADBEEF -> o_mem_we=1 that cycle, o_cpu_stall=0. Read back of 0x10 -> o_cpu_rdata=0xDEADBEEF in the same cycle.
- Debug only: dbg read of 0x10 with CPU idle -> o_dbg_gnt=1 same cycle; o_dbg_rvalid=1 with o_dbg_rdata=0xDEADBEEF next cycle, then 0.
- Starvation: CPU requests every cycle, dbg write 0x20=0x5 requested at cycle 0 -> o_dbg_gnt=0 for cycles 0..7, =1 at cycle 8 with o_cpu_stall=1 in that cycle only.
- Lock burst: dbg writes 4 words 0x40..0x4C with i_dbg_lock=1 on the first 3 and 0 on the last, CPU requesting -> o_cpu_stall=1 for 4 cycles, all 4 writes land, CPU resumes on cycle 5.
- Forced release: LOCK_MAX=4, i_dbg_lock held 1 with continuous requests from both -> 5 debug grants (the initial ARB grant plus 4 LOCK cycles), then one GUARD cycle with the CPU unstalled and o_dbg_gnt=0, then normal arbitration.
- Reset mid-LOCK with a read issued the previous cycle -> next cycle o_dbg_rvalid=0, state ARB, o_mem_we=0 during rst; a CPU request after rst release is granted immediately.
